// File: rtl/arp_controller_if.sv
// arp_controller_if: groups the key/switch inputs and the engine-facing
// outputs of arp_controller into one bundle.
//   master - the side that drives keys, switches, rate and tap (board/bench)
//   slave  - the arp_controller itself
interface arp_controller_if;
  logic [3:0]  key_in;
  logic        arp_on;
  logic        latch_mode;
  logic [2:0]  rate_sel;
  logic        tap;
  logic [3:0]  key_out;
  logic        arp_enable;
  logic [15:0] countermax;
  logic        latched;

  modport master (
    output key_in,
    output arp_on,
    output latch_mode,
    output rate_sel,
    output tap,
    input  key_out,
    input  arp_enable,
    input  countermax,
    input  latched
  );

  modport slave (
    input  key_in,
    input  arp_on,
    input  latch_mode,
    input  rate_sel,
    input  tap,
    output key_out,
    output arp_enable,
    output countermax,
    output latched
  );
endinterface

// File: rtl/arp_controller.sv
// arp_controller: front end for the Arpeggiator step engine.
// Conditions the four key inputs (live chord or latched chord), gates the
// engine Enable, and produces the 16-bit countermax step period from a rate
// selector. All outputs are registered; RESET is synchronous, active-high.
//
// Optional feature: define ARP_TAP_TEMPO_EN to add tap-tempo measurement.
// The interval between two taps (in clocks, shifted right by TAP_SHIFT) then
// replaces BASE_PERIOD as the base period. Without the macro, tap is ignored.
module arp_controller #(
  parameter logic [15:0] BASE_PERIOD = 16'd50000,
  parameter int unsigned TAP_SHIFT   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  arp_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LATCHED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  chord;
  logic [3:0]  chord_next;
  logic [3:0]  key_prev;
  logic        arp_enable;
  logic        latched;
  logic [15:0] period_base;
  logic [15:0] period_shifted;
  logic [15:0] countermax;
  logic [15:0] countermax_next;

  // The engine sees the registered chord, enable, status and period directly
  assign bus.key_out    = chord;
  assign bus.arp_enable = arp_enable;
  assign bus.latched    = latched;
  assign bus.countermax = countermax;

  // Next state and next chord; the master switch overrides every other rule
  always_comb begin
    state_next = state;
    chord_next = chord;
    case (state)
      IDLE: begin
        chord_next = 4'd0;
        if (bus.arp_on) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (bus.latch_mode) begin
          // A press after a full release starts a new chord; otherwise
          // keys accumulate into the held chord.
          if ((key_prev == 4'd0) && (bus.key_in != 4'd0)) begin
            chord_next = bus.key_in;
          end else begin
            chord_next = chord | bus.key_in;
          end
          if ((bus.key_in == 4'd0) && (chord != 4'd0)) begin
            state_next = LATCHED;
          end else begin
            state_next = RUN;
          end
        end else begin
          chord_next = bus.key_in;
          state_next = RUN;
        end
      end
      LATCHED: begin
        if (bus.key_in != 4'd0) begin
          state_next = RUN;
          chord_next = bus.key_in;
        end else if (!bus.latch_mode) begin
          state_next = RUN;
          chord_next = 4'd0;
        end else begin
          state_next = LATCHED;
          chord_next = chord;
        end
      end
      default: begin
        state_next = IDLE;
        chord_next = 4'd0;
      end
    endcase
    if (!bus.arp_on) begin
      state_next = IDLE;
      chord_next = 4'd0;
    end else begin
      state_next = state_next;
    end
  end

  // State, chord, previous-key history and the derived status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      chord      <= 4'd0;
      key_prev   <= 4'd0;
      arp_enable <= 1'b0;
      latched    <= 1'b0;
    end else begin
      state      <= state_next;
      chord      <= chord_next;
      key_prev   <= bus.key_in;
      arp_enable <= (state_next != IDLE) && (chord_next != 4'd0);
      latched    <= (state_next == LATCHED);
    end
  end

  // Rate division; a shift past all significant bits clamps to one clock
  always_comb begin
    period_shifted = period_base >> bus.rate_sel;
    if (period_shifted == 16'd0) begin
      countermax_next = 16'd1;
    end else begin
      countermax_next = period_shifted;
    end
  end

  // Step period register feeding the engine
  always_ff @(posedge CLK) begin
    if (RESET) begin
      countermax <= BASE_PERIOD;
    end else begin
      countermax <= countermax_next;
    end
  end

`ifdef ARP_TAP_TEMPO_EN
  localparam logic [23:0] TAP_CNT_SAT = 24'hFFFFFF;

  logic [23:0] tap_cnt;
  logic [23:0] tap_scaled;
  logic [15:0] tap_period;

  // Scale the measured interval and clamp it into the 16-bit period range
  always_comb begin
    tap_scaled = tap_cnt >> TAP_SHIFT;
    if (tap_scaled == 24'd0) begin
      tap_period = 16'd1;
    end else if (tap_scaled > 24'h00FFFF) begin
      tap_period = 16'hFFFF;
    end else begin
      tap_period = tap_scaled[15:0];
    end
  end

  // Tap interval counter and captured base period; a saturated counter
  // means there was no previous tap, so that tap only restarts timing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tap_cnt     <= TAP_CNT_SAT;
      period_base <= BASE_PERIOD;
    end else if (bus.tap) begin
      tap_cnt <= 24'd0;
      if (tap_cnt != TAP_CNT_SAT) begin
        period_base <= tap_period;
      end else begin
        period_base <= period_base;
      end
    end else begin
      period_base <= period_base;
      if (tap_cnt != TAP_CNT_SAT) begin
        tap_cnt <= tap_cnt + 24'd1;
      end else begin
        tap_cnt <= tap_cnt;
      end
    end
  end
`else
  localparam int unsigned unused_tap_shift = TAP_SHIFT;
  logic unused_tap;

  // Without tap tempo the base period is fixed and the tap input is dropped
  assign period_base = BASE_PERIOD;
  assign unused_tap  = bus.tap;
`endif

endmodule

// File: tb/tb_arp_controller.sv
// tb_arp_controller: directed scenarios followed by randomized stimulus, all
// compared against a behavioural model of the controller's rules. A second
// instance with BASE_PERIOD=4 covers the clamp-to-one period case.
// Build with or without ARP_TAP_TEMPO_EN; expectations follow the macro.
module tb_arp_controller;

  localparam int BASE   = 50000;
  localparam int TSHIFT = 8;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  arp_controller_if a_if ();
  arp_controller_if b_if ();

  arp_controller #(.BASE_PERIOD(16'd50000), .TAP_SHIFT(TSHIFT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (a_if)
  );

  arp_controller #(.BASE_PERIOD(16'd4), .TAP_SHIFT(TSHIFT)) dut_small (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: mode 0 = idle, 1 = running, 2 = holding a latched chord
  int         m_mode;
  logic [3:0] m_chord;
  logic [3:0] m_prev;
  int         m_cm;
  int         m_pb;
  int         m_tcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_edge();
    logic [3:0] k;
    logic [3:0] c;
    int         shifted;
    int         scaled;
    k = a_if.key_in;
    if (RESET) begin
      m_mode  = 0;
      m_chord = 4'd0;
      m_prev  = 4'd0;
      m_cm    = BASE;
      m_pb    = BASE;
      m_tcnt  = 16777215;
    end else begin
      shifted = m_pb / (1 << a_if.rate_sel);
      m_cm    = (shifted < 1) ? 1 : shifted;
`ifdef ARP_TAP_TEMPO_EN
      if (a_if.tap) begin
        if (m_tcnt != 16777215) begin
          scaled = m_tcnt / (1 << TSHIFT);
          m_pb   = (scaled < 1) ? 1 : ((scaled > 65535) ? 65535 : scaled);
        end
        m_tcnt = 0;
      end else if (m_tcnt < 16777215) begin
        m_tcnt = m_tcnt + 1;
      end
`else
      scaled = 0;
`endif
      c = m_chord;
      if (!a_if.arp_on) begin
        m_mode  = 0;
        m_chord = 4'd0;
      end else if (m_mode == 0) begin
        m_mode  = 1;
        m_chord = 4'd0;
      end else if (m_mode == 1) begin
        if (!a_if.latch_mode) begin
          m_chord = k;
        end else begin
          m_chord = (m_prev == 4'd0 && k != 4'd0) ? k : (c | k);
          if (k == 4'd0 && c != 4'd0) m_mode = 2;
        end
      end else begin
        if (k != 4'd0) begin
          m_mode  = 1;
          m_chord = k;
        end else if (!a_if.latch_mode) begin
          m_mode  = 1;
          m_chord = 4'd0;
        end
      end
      m_prev = k;
    end
  endtask

  // One clock edge: update the model, then compare all outputs just after it
  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check({tag, ".key_out"},    32'(a_if.key_out),    32'(m_chord));
    check({tag, ".arp_enable"}, 32'(a_if.arp_enable), 32'((m_mode != 0) && (m_chord != 4'd0)));
    check({tag, ".latched"},    32'(a_if.latched),    32'(m_mode == 2));
    check({tag, ".countermax"}, 32'(a_if.countermax), 32'(m_cm));
  endtask

  task automatic drive(input logic rst, input logic on, input logic lm,
                       input logic [3:0] k, input logic [2:0] rs, input logic tp);
    RESET           = rst;
    a_if.arp_on     = on;
    a_if.latch_mode = lm;
    a_if.key_in     = k;
    a_if.rate_sel   = rs;
    a_if.tap        = tp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_mode = 0; m_chord = 4'd0; m_prev = 4'd0;
    m_cm = BASE; m_pb = BASE; m_tcnt = 16777215;
    b_if.key_in = 4'd0; b_if.arp_on = 1'b0; b_if.latch_mode = 1'b0;
    b_if.rate_sel = 3'd0; b_if.tap = 1'b0;

    // Reset and rate division
    drive(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
    step("reset");
    check("reset.cm_const", 32'(a_if.countermax), 32'd50000);
    check("small.reset_cm", 32'(b_if.countermax), 32'd4);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
    step("arp_on");
    check("rate0.cm", 32'(a_if.countermax), 32'd50000);
    a_if.rate_sel = 3'd3;
    b_if.rate_sel = 3'd7;
    step("rate3");
    check("rate3.cm", 32'(a_if.countermax), 32'd6250);
    check("small.rate7_cm", 32'(b_if.countermax), 32'd1);
    b_if.rate_sel = 3'd1;
    a_if.rate_sel = 3'd0;
    step("rate0");
    check("small.rate1_cm", 32'(b_if.countermax), 32'd2);

    // Live mode
    a_if.key_in = 4'b0101;
    step("live_press");
    check("live.key_out", 32'(a_if.key_out), 32'd5);
    check("live.enable", 32'(a_if.arp_enable), 32'd1);
    a_if.key_in = 4'b0000;
    step("live_release");
    check("live.release_en", 32'(a_if.arp_enable), 32'd0);

    // Latch mode: build 0101, release, then a fresh press replaces it
    a_if.latch_mode = 1'b1;
    a_if.key_in = 4'b0001; step("latch_p1");
    a_if.key_in = 4'b0101; step("latch_p2");
    a_if.key_in = 4'b0000; step("latch_rel");
    check("latch.key_out", 32'(a_if.key_out), 32'd5);
    check("latch.latched", 32'(a_if.latched), 32'd1);
    a_if.key_in = 4'b1000; step("latch_new");
    check("latch.new_key", 32'(a_if.key_out), 32'd8);
    check("latch.unlatched", 32'(a_if.latched), 32'd0);

    // Master switch drop while pressing a key in LATCHED
    a_if.key_in = 4'b0000; step("ms_rel1");
    a_if.key_in = 4'b0101; step("ms_press");
    a_if.key_in = 4'b0000; step("ms_rel2");
    check("ms.latched_0101", 32'(a_if.key_out), 32'd5);
    a_if.arp_on = 1'b0; a_if.key_in = 4'b0010; step("ms_drop");
    check("ms.key_out", 32'(a_if.key_out), 32'd0);
    check("ms.enable", 32'(a_if.arp_enable), 32'd0);

    // Same, but via reset
    a_if.arp_on = 1'b1; a_if.key_in = 4'b0000; step("rs_on");
    a_if.key_in = 4'b0101; step("rs_press");
    a_if.key_in = 4'b0000; step("rs_rel");
    check("rs.latched", 32'(a_if.latched), 32'd1);
    RESET = 1'b1; a_if.key_in = 4'b0010; step("rs_reset");
    check("rs.key_out", 32'(a_if.key_out), 32'd0);
    check("rs.latched_clr", 32'(a_if.latched), 32'd0);

    // Tap tempo: first tap after reset only starts timing
    drive(1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1);
    step("tap1");
    a_if.tap = 1'b0;
    step("tap1_post");
    check("tap.first_unchanged", 32'(a_if.countermax), 32'd50000);
    for (int i = 0; i < 25599; i++) step("tap_wait");
    a_if.tap = 1'b1;
    step("tap2_capture");
    a_if.tap = 1'b0;
    step("tap2_shift");
`ifdef ARP_TAP_TEMPO_EN
    check("tap.period", 32'(a_if.countermax), 32'd100);
`else
    check("tap.ignored", 32'(a_if.countermax), 32'd50000);
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      RESET       = ($urandom_range(0, 199) == 0);
      a_if.arp_on = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 9) == 0) a_if.latch_mode = ~a_if.latch_mode;
      a_if.key_in = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a_if.rate_sel = 3'($urandom_range(0, 7));
      a_if.tap    = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arp_controller.md
# arp_controller

Front-end controller for the `Arpeggiator` step engine. It conditions the four key inputs (live or latched chord) and drives the engine's `Enable` gate. It also computes the engine's 16-bit `countermax` step period from a rate selector and, optionally, from a tap-tempo measurement. It sits between the key/switch inputs and the `Arpeggiator` instance; its outputs connect directly to that instance's `key0..key3`, `Enable` and `countermax`.

## Interface
- `BASE_PERIOD`, default 16'd50000: step period in clocks at `rate_sel`=0 when tap tempo is off or not yet captured.
- `TAP_SHIFT`, default 8: right shift applied to the measured tap interval to form the base period.
- `CLK`, input, 1: system clock. There is only one clock; all state updates on its rising edge.
- `RESET`, input, 1: reset, synchronous and active-high.
- `key_in`, input, 4: live key levels; bit n maps to key n.
- `arp_on`, input, 1: arpeggiator master switch.
- `latch_mode`, input, 1: when set, releasing all keys holds the last chord.
- `rate_sel`, input, 3: rate divider; period = base >> `rate_sel`.
- `tap`, input, 1: single-cycle tap pulse, already clean and synchronous.
- `key_out`, output, 4: chord to the engine (`key0`=bit0 … `key3`=bit3).
- `arp_enable`, output, 1: drives the engine's `Enable`.
- `countermax`, output, 16: drives the engine's `countermax`.
- `latched`, output, 1: status; high while in LATCHED.

## Operation
- **States** (2-bit): IDLE, RUN, LATCHED.
- **IDLE**
  - `key_out`=0 and `arp_enable`=0.
  - Goes to RUN when `arp_on`=1.
- **RUN**
  - With `latch_mode`=0: `chord <= key_in`.
  - With `latch_mode`=1:
    - If previous `key_in` was 0 and current `key_in`≠0: `chord <= key_in` (a new chord starts).
    - Otherwise: `chord <= chord | key_in`.
  - Goes to LATCHED when `latch_mode`=1, `key_in`=0 and `chord`≠0. `chord` is not cleared on this transition.
- **LATCHED**
  - `chord` is held.
  - Goes to RUN with `chord <= key_in` when `key_in`≠0.
  - Goes to RUN with `chord <= 0` when `latch_mode`=0.
- **Global**
  - `arp_on`=0 in any state forces IDLE next edge and clears `chord`. This has priority over every other transition.
  - `key_out` = `chord`.
  - `arp_enable` = (state≠IDLE) & (next `chord`≠0).
  - `latched` = (state==LATCHED).
- **Period**
  - `period_base` (16 bit) = `BASE_PERIOD`, or the captured tap value (see Configuration).
  - `countermax <= max(period_base >> rate_sel, 1)`.
  - The result is never 0; shifts beyond the significant bits clamp to 1.
- **Simultaneous events:** `arp_on` falling and a key press on the same edge → IDLE; the key is ignored.

## Timing
- All outputs are registered.
- **Key path:** `key_in` → `key_out` latency is 1 cycle.
- **Enable:** `arp_enable` updates on the same edge as `key_out`.
- **State change:** takes effect on the edge where the condition is sampled; outputs reflect the new state after that edge.
- **`countermax`:**
  - Follows a `rate_sel` change in 1 cycle.
  - Follows a new tap capture in 2 cycles (capture edge, then shift edge).
- **Reset values:**
  - state = IDLE, `key_out`=0, `arp_enable`=0, `latched`=0.
  - `countermax`=`BASE_PERIOD`, `period_base`=`BASE_PERIOD`.
  - Tap counter = saturated (no prior tap).
- **Reset mid-operation:** reset on any edge returns every register to its reset value on that edge, including a held LATCHED chord and any tap measurement in progress.

## Configuration
- Macro `ARP_TAP_TEMPO_EN`.
- **Defined:**
  - A 24-bit `tap_cnt` increments every cycle and saturates at 24'hFFFFFF.
  - On `tap`=1 with `tap_cnt` not saturated: `period_base <= clamp(tap_cnt >> TAP_SHIFT, 1, 16'hFFFF)`.
  - On every `tap`, `tap_cnt` resets to 0.
  - A tap with `tap_cnt` saturated is a first tap: the counter restarts and `period_base` is unchanged.
  - The tap path is independent of state; tapping in IDLE is legal.
- **Undefined:** no tap logic is present, `tap` is ignored, and `period_base` is constant `BASE_PERIOD`.

## Test plan
- **Reset / rate:** reset, `arp_on`=1, `rate_sel`=0 → `countermax`=50000. Then `rate_sel`=3 → 6250 after 1 cycle. With `BASE_PERIOD`=4 and `rate_sel`=7 → `countermax`=1.
- **Live mode:** `latch_mode`=0, `key_in`=4'b0101 → `key_out`=0101 and `arp_enable`=1 one cycle later. Then `key_in`=0 → `key_out`=0 and `arp_enable`=0 one cycle later.
- **Latch mode:** `latch_mode`=1. Press 0001, then add 0100, then release all → `key_out`=0101, `latched`=1. Then press 1000 → `key_out`=1000, `latched`=0.
- **Master switch:** in LATCHED with `key_out`=0101, drop `arp_on` while pressing 0010 → next edge IDLE, `key_out`=0, `arp_enable`=0. Repeat with `RESET`=1 instead of `arp_on`=0 → same result.
- **Tap tempo** (`ARP_TAP_TEMPO_EN`, `TAP_SHIFT`=8): taps 25600 cycles apart → `countermax`=100 two cycles after the second tap. A first tap after saturation leaves `countermax` unchanged.
- **Tap ignored:** without `ARP_TAP_TEMPO_EN`, the same tap sequence → `countermax` stays 50000.
